serial_adder: RTL and testbench

Parametrised bit-serial adder: adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, using one DIGIT-wide full-adder cell and a registered carry. It is the sequential, multi-cycle successor to the single-bit full adder, trading latency for area. Datapath blocks use it where a wide combinational adder is too costly, driving it with a start/done handshake.

---
 rtl/serial_adder.sv | 112 +++++++++++
 tb/tb_serial_adder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: adds a + b + c, DIGIT bits per clock, through one DIGIT-wide ripple cell.
// Optional SERIAL_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STEPS = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa, opb, wsum, wsum_nx;
  logic             cr;
  logic [KW-1:0]    k;
  logic [DIGIT-1:0] ds;
  logic [DIGIT:0]   cc;

  // Operands shift right each step, so the current digit always sits at the bottom.
  assign cc[0] = cr;
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign ds[i]   = opa[i] ^ opb[i] ^ cc[i];
    assign cc[i+1] = (opa[i] & opb[i]) | (cc[i] & (opa[i] ^ opb[i]));
  end

  // Working sum fills from the top; after STEPS shifts the digits are in place.
  if (STEPS == 1) begin : g_one
    assign wsum_nx = ds;
  end else begin : g_many
    assign wsum_nx = {ds, wsum[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      opa   <= '0;
      opb   <= '0;
      cr    <= 1'b0;
      k     <= '0;
      wsum  <= '0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            cr    <= c;
            k     <= '0;
            state <= S_RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
            ready <= 1'b1;
          end
        end
        S_RUN: begin
          opa  <= opa >> DIGIT;
          opb  <= opb >> DIGIT;
          cr   <= cc[DIGIT];
          wsum <= wsum_nx;
          k    <= k + 1'b1;
          if (k == KW'(STEPS - 1)) begin
            sum   <= wsum_nx;
            carry <= cc[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= cc[DIGIT] ^ cc[DIGIT-1];
`endif
            state <= S_DONE;
            busy  <= 1'b0;
            ready <= 1'b1;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: four instances (DIGIT 1,2,4,8) checked every cycle against
// a countdown/arithmetic model, plus hand-computed literal results.
module tb_serial_adder;
  localparam int W  = 8;
  localparam int NG = 4;
  localparam int DG [NG] = '{1, 2, 4, 8};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NG-1:0] start = '0;
  logic [NG-1:0] ready, busy, done, carry;
  logic [W-1:0]  a = '0, b = '0;
  logic          c = 1'b0;
  logic [W-1:0]  sum [NG];
`ifdef SERIAL_ADDER_OVF_EN
  logic [NG-1:0] ovf;
`endif

  for (genvar g = 0; g < NG; g++) begin : g_dut
    serial_adder #(.WIDTH(W), .DIGIT(DG[g])) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .a(a), .b(b), .c(c),
      .ready(ready[g]), .busy(busy[g]), .done(done[g]), .sum(sum[g]), .carry(carry[g])
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf[g])
`endif
    );
  end

  int npass = 0, ntot = 0;

  task automatic chk(input string nm, input int g, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s dut%0d got %0h expected %0h at %0t", nm, g, got, exp, $time);
  endtask

  // Model: an accepted op completes STEPS edges later with {carry,sum} = a+b+c.
  int           rem   [NG];
  logic [W:0]   res   [NG];
  logic         rovf  [NG];
  logic         e_done[NG];
  logic [W-1:0] e_sum [NG];
  logic         e_car [NG];
  logic         e_ovf [NG];
  bit           armed = 0;

  always @(posedge clk) begin
    for (int g = 0; g < NG; g++) begin
      if (rst) begin
        rem[g] = 0; e_done[g] = 0; e_sum[g] = '0; e_car[g] = 0; e_ovf[g] = 0;
      end else if (rem[g] > 0) begin
        rem[g]--;
        if (rem[g] == 0) begin
          e_done[g] = 1;
          {e_car[g], e_sum[g]} = res[g];
          e_ovf[g] = rovf[g];
        end
      end else begin
        e_done[g] = 0;
        if (start[g]) begin
          int sv;
          rem[g] = W / DG[g];
          res[g] = {1'b0, a} + {1'b0, b} + {8'd0, c};
          sv = int'($signed(a)) + int'($signed(b)) + int'(c);
          rovf[g] = (sv > 127) || (sv < -128);
        end
      end
    end
    if (rst) armed = 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int g = 0; g < NG; g++) begin
        chk("ready", g, 32'(ready[g]), 32'(rem[g] == 0));
        chk("busy",  g, 32'(busy[g]),  32'(rem[g] > 0));
        chk("done",  g, 32'(done[g]),  32'(e_done[g]));
        chk("sum",   g, 32'(sum[g]),   32'(e_sum[g]));
        chk("carry", g, 32'(carry[g]), 32'(e_car[g]));
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf",   g, 32'(ovf[g]),   32'(e_ovf[g]));
`endif
      end
    end
  end

  task automatic issue(input int g, input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc);
    int n = 0;
    while (!ready[g] && n < 200) begin @(negedge clk); n++; end
    if (!ready[g]) begin ntot++; $display("FAIL ready_timeout dut%0d got 0 expected 1", g); end
    a = aa; b = bb; c = cc; start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, output int n);
    n = 0;
    while (!done[g] && n < 200) begin @(negedge clk); n++; end
    if (!done[g]) begin ntot++; $display("FAIL done_timeout dut%0d got 0 expected 1", g); end
  endtask

  initial begin
    int n, nd;
    logic [W-1:0] ra, rb;
    logic rc;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 0, 32'(ready[0]), 32'd1);
    chk("rst_busy",  0, 32'(busy[0]),  32'd0);
    chk("rst_sum",   0, 32'(sum[0]),   32'd0);
    chk("rst_carry", 0, 32'(carry[0]), 32'd0);

    nd = 0;
    repeat (20) begin @(negedge clk); nd += $countones(done); end
    chk("idle_nodone", 0, nd, 0);

    // 3C + 5A: 9 edges including the accepting one
    issue(0, 8'h3C, 8'h5A, 1'b0);
    wait_done(0, n);
    chk("lat_d1",   0, n, 8);
    chk("sum_96",   0, 32'(sum[0]), 32'h96);
    chk("carry_96", 0, 32'(carry[0]), 32'd0);
    chk("model_96", 0, 32'(e_sum[0]), 32'h96);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf_96",   0, 32'(ovf[0]), 32'd1);
`endif

    // FF + 00 + 1 while inputs and start churn during RUN
    issue(0, 8'hFF, 8'h00, 1'b1);
    repeat (3) begin
      a = W'($urandom); b = W'($urandom); c = ~c; start[0] = ~start[0];
      @(negedge clk);
    end
    start[0] = 1'b0;
    wait_done(0, n);
    chk("sum_ff1",   0, 32'(sum[0]), 32'h00);
    chk("carry_ff1", 0, 32'(carry[0]), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf_ff1",   0, 32'(ovf[0]), 32'd0);
`endif

    // DIGIT=4: FF+FF+1, then back-to-back start in the DONE cycle
    issue(2, 8'hFF, 8'hFF, 1'b1);
    wait_done(2, n);
    chk("lat_d4",    2, n, 2);
    chk("sum_ffff",  2, 32'(sum[2]), 32'hFF);
    chk("carry_ffff",2, 32'(carry[2]), 32'd1);
    a = 8'd1; b = 8'd2; c = 1'b0; start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    chk("b2b_busy",  2, 32'(busy[2]), 32'd1);
    wait_done(2, n);
    chk("sum_3",     2, 32'(sum[2]), 32'd3);
    chk("carry_3",   2, 32'(carry[2]), 32'd0);

    // reset during the 4th RUN cycle of an 8-step add
    issue(0, 8'h55, 8'h66, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_sum",   0, 32'(sum[0]), 32'd0);
    chk("mid_rst_carry", 0, 32'(carry[0]), 32'd0);
    chk("mid_rst_busy",  0, 32'(busy[0]), 32'd0);
    nd = 0;
    repeat (12) begin @(negedge clk); nd += $countones(done); end
    chk("mid_rst_nodone", 0, nd, 0);
    issue(0, 8'h10, 8'h20, 1'b0);
    wait_done(0, n);
    chk("sum_30", 0, 32'(sum[0]), 32'h30);

    // start together with reset is dropped
    rst = 1'b1; start[0] = 1'b1; a = 8'h01; b = 8'h01;
    @(negedge clk);
    rst = 1'b0; start[0] = 1'b0;
    chk("rst_start_busy", 0, 32'(busy[0]), 32'd0);
    @(negedge clk);

    // random ops for DIGIT 1, 2, 8 with junk on the inputs while running
    foreach (DG[g]) begin
      if (DG[g] != 4) begin
        repeat (1000) begin
          ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
          issue(g, ra, rb, rc);
          a = W'($urandom); b = W'($urandom); c = 1'($urandom);
          wait_done(g, n);
          chk("rand_res", g, 32'({carry[g], sum[g]}), 32'({1'b0, ra} + {1'b0, rb} + {8'd0, rc}));
        end
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
